// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types used by the pipeline sequencer
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  // One bit per pipeline latch control driven by the sequencer.
  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic ifidFlush;
    logic idexEn;
    logic idexFlush;
    logic idexFreeze;
    logic exmemEn;
    logic exmemFlush;
    logic memwbEn;
    logic memwbFlush;
  } pctrl_ctrl_t;

endpackage

// File: rtl/pctrl_sat_cnt.sv
// rtl/pctrl_sat_cnt.sv - event counter that sticks at all-ones instead of wrapping
module pctrl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: latch enables/flushes, halt, D-wait watchdog
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_redirect,
  input  logic             ex_dREN,
  input  regbits_t         ex_rd,
  input  regbits_t         id_rs1,
  input  regbits_t         id_rs2,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             idex_freeze,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW_W = $clog2(TIMEOUT) + 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(TIMEOUT - 1);

  pctrl_state_t state, nextState;
  pctrl_ctrl_t  ctrl;
  logic [DW_W-1:0]  dwaitCnt;
  logic [CNT_W-1:0] stallQ, flushQ;
  logic memTimeoutQ;
  logic memOp, dStall, loadUse;
  logic stallInc, flushInc;

  assign memOp   = mem_dREN | mem_dWEN;
  assign dStall  = memOp & ~dhit;
  assign loadUse = ex_dREN & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Rules are strictly prioritised; a pending redirect during a D-miss simply
  // stays asserted in EX (idex_en=0) and wins on the dhit cycle.
  always_comb begin
    nextState = state;
    ctrl      = '0;
    stallInc  = 1'b0;
    flushInc  = 1'b0;
    if (!RST && (state != HALTED)) begin
      if (wb_halt) begin
        nextState = HALTED;
      end else if (dStall) begin
        nextState       = DWAIT;
        ctrl.memwbFlush = 1'b1;
        stallInc        = 1'b1;
      end else begin
        nextState = RUN;
        if (ex_redirect) begin
          ctrl.pcEn      = 1'b1;
          ctrl.ifidFlush = 1'b1;
          ctrl.idexFlush = 1'b1;
          ctrl.exmemEn   = 1'b1;
          ctrl.memwbEn   = 1'b1;
          flushInc       = 1'b1;
        end else if (loadUse) begin
          ctrl.idexFreeze = 1'b1;
          ctrl.exmemEn    = 1'b1;
          ctrl.memwbEn    = 1'b1;
          stallInc        = 1'b1;
        end else if (!ihit) begin
          ctrl.ifidFlush = 1'b1;
          ctrl.idexEn    = 1'b1;
          ctrl.exmemEn   = 1'b1;
          ctrl.memwbEn   = 1'b1;
          stallInc       = 1'b1;
        end else begin
          ctrl.pcEn    = 1'b1;
          ctrl.ifidEn  = 1'b1;
          ctrl.idexEn  = 1'b1;
          ctrl.exmemEn = 1'b1;
          ctrl.memwbEn = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      dwaitCnt    <= '0;
      memTimeoutQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DWAIT && dwaitCnt == DW_LAST) begin
        memTimeoutQ <= 1'b1;
      end
      // Count only cycles spent in DWAIT; the counter parks at its last value.
      if (state == DWAIT && nextState == DWAIT) begin
        if (dwaitCnt != DW_LAST) dwaitCnt <= dwaitCnt + 1'b1;
      end else begin
        dwaitCnt <= '0;
      end
    end
  end

  pctrl_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .inc  (stallInc),
    .clr  (RST),
    .count(stallQ)
  );

  pctrl_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .inc  (flushInc),
    .clr  (RST),
    .count(flushQ)
  );

  assign pc_en       = ctrl.pcEn;
  assign ifid_en     = ctrl.ifidEn;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_en     = ctrl.idexEn;
  assign idex_flush  = ctrl.idexFlush;
  assign idex_freeze = ctrl.idexFreeze;
  assign exmem_en    = ctrl.exmemEn;
  assign exmem_flush = ctrl.exmemFlush;
  assign memwb_en    = ctrl.memwbEn;
  assign memwb_flush = ctrl.memwbFlush;

  // Status outputs read zero for the whole time reset is held.
  assign halt        = ~RST & (state == HALTED);
  assign mem_timeout = ~RST & memTimeoutQ;
  assign stall_cnt   = stallQ & {CNT_W{~RST}};
  assign flush_cnt   = flushQ & {CNT_W{~RST}};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a rule-table model
module tb_pipeline_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST, ihit, dhit, mem_dREN, mem_dWEN, ex_redirect, ex_dREN, wb_halt;
  logic [4:0] ex_rd, id_rs1, id_rs2;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
  //  exmem_en, exmem_flush, memwb_en, memwb_flush, halt, mem_timeout}
  logic [11:0] ctlA, ctlB;
  logic [15:0] stallA, flushA;
  logic [1:0]  stallB, flushB;

  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(16)) dutA (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_redirect(ex_redirect), .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_halt(wb_halt),
    .pc_en(ctlA[11]), .ifid_en(ctlA[10]), .ifid_flush(ctlA[9]), .idex_en(ctlA[8]),
    .idex_flush(ctlA[7]), .idex_freeze(ctlA[6]), .exmem_en(ctlA[5]), .exmem_flush(ctlA[4]),
    .memwb_en(ctlA[3]), .memwb_flush(ctlA[2]), .halt(ctlA[1]), .mem_timeout(ctlA[0]),
    .stall_cnt(stallA), .flush_cnt(flushA)
  );

  pipeline_ctrl #(.CNT_W(2), .TIMEOUT(4)) dutB (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_redirect(ex_redirect), .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_halt(wb_halt),
    .pc_en(ctlB[11]), .ifid_en(ctlB[10]), .ifid_flush(ctlB[9]), .idex_en(ctlB[8]),
    .idex_flush(ctlB[7]), .idex_freeze(ctlB[6]), .exmem_en(ctlB[5]), .exmem_flush(ctlB[4]),
    .memwb_en(ctlB[3]), .memwb_flush(ctlB[2]), .halt(ctlB[1]), .mem_timeout(ctlB[0]),
    .stall_cnt(stallB), .flush_cnt(flushB)
  );

  int nCmp = 0;
  int nFail = 0;

  int mTimeoutLim[2] = '{16, 4};
  int mCntMax[2]     = '{65535, 3};
  bit mHalted, mWait;
  int mDw;
  bit mTo[2];
  int mStall[2], mFlush[2];

  task automatic checkEq(input string tag, input int obs, input int exp);
    nCmp++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Which priority rule applies this cycle: -1 reset, 0 halted, 1..6 rule number.
  function automatic int rule();
    bit memop;
    memop = mem_dREN | mem_dWEN;
    if (RST) return -1;
    if (mHalted) return 0;
    if (wb_halt) return 1;
    if (memop && !dhit) return 2;
    if (ex_redirect) return 3;
    if (ex_dREN && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)) return 4;
    if (!ihit) return 5;
    return 6;
  endfunction

  function automatic logic [10:0] expCtl(input int r);
    logic pc, ifE, ifF, idE, idF, idZ, exE, exF, wbE, wbF, h;
    {pc, ifE, ifF, idE, idF, idZ, exE, exF, wbE, wbF, h} = '0;
    case (r)
      0: h = 1'b1;
      2: wbF = 1'b1;
      3: begin pc = 1'b1; ifF = 1'b1; idF = 1'b1; exE = 1'b1; wbE = 1'b1; end
      4: begin idZ = 1'b1; exE = 1'b1; wbE = 1'b1; end
      5: begin ifF = 1'b1; idE = 1'b1; exE = 1'b1; wbE = 1'b1; end
      6: begin pc = 1'b1; ifE = 1'b1; idE = 1'b1; exE = 1'b1; wbE = 1'b1; end
      default: ;
    endcase
    return {pc, ifE, ifF, idE, idF, idZ, exE, exF, wbE, wbF, h};
  endfunction

  task automatic modelUpdate(input int r);
    if (r < 0) begin
      mHalted = 0; mWait = 0; mDw = 0;
      for (int i = 0; i < 2; i++) begin mTo[i] = 0; mStall[i] = 0; mFlush[i] = 0; end
    end else if (r > 0) begin
      for (int i = 0; i < 2; i++) begin
        if (mWait && mDw >= mTimeoutLim[i] - 1) mTo[i] = 1;
        if ((r == 2 || r == 4 || r == 5) && mStall[i] < mCntMax[i]) mStall[i]++;
        if (r == 3 && mFlush[i] < mCntMax[i]) mFlush[i]++;
      end
      if (r == 1) begin
        mHalted = 1; mWait = 0; mDw = 0;
      end else if (r == 2) begin
        if (mWait) mDw++;
        mWait = 1;
      end else begin
        mWait = 0; mDw = 0;
      end
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    int r;
    logic [10:0] e;
    #1;
    r = rule();
    e = expCtl(r);
    checkEq("ctlA", int'(ctlA[11:1]), int'(e));
    checkEq("ctlB", int'(ctlB[11:1]), int'(e));
    checkEq("timeoutA", int'(ctlA[0]), RST ? 0 : int'(mTo[0]));
    checkEq("timeoutB", int'(ctlB[0]), RST ? 0 : int'(mTo[1]));
    checkEq("stallA", int'(stallA), RST ? 0 : mStall[0]);
    checkEq("stallB", int'(stallB), RST ? 0 : mStall[1]);
    checkEq("flushA", int'(flushA), RST ? 0 : mFlush[0]);
    checkEq("flushB", int'(flushB), RST ? 0 : mFlush[1]);
    @(posedge CLK);
    modelUpdate(r);
    @(negedge CLK);
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_redirect = 0;
    ex_dREN = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; wb_halt = 0;
  endtask

  task automatic doReset();
    idle(); RST = 1; cycle(); cycle(); RST = 0;
  endtask

  initial begin
    modelUpdate(-1);
    doReset();
    cycle();
    checkEq("post_reset_stall", int'(stallA), 0);

    // Load-use on rs2, then the same with rd=x0 which must not stall.
    ex_dREN = 1; ex_rd = 5; id_rs2 = 5; cycle();
    idle(); cycle();
    ex_dREN = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; cycle();
    idle();
    checkEq("lu_stall_cnt", int'(stallA), 1);

    // D-miss for three cycles, released by dhit.
    mem_dREN = 1;
    repeat (3) cycle();
    dhit = 1; cycle();
    idle(); cycle();
    checkEq("dmiss_stall_cnt", int'(stallA), 4);

    // Redirect held behind a D-miss, applied on the dhit cycle; then redirect with ihit=0.
    ex_redirect = 1; mem_dWEN = 1;
    repeat (2) cycle();
    dhit = 1; cycle();
    checkEq("redirect_flush_cnt", int'(flushA), 1);
    idle(); ex_redirect = 1; ihit = 0; cycle();
    idle(); cycle();

    // Halt is sticky across toggling inputs until reset.
    wb_halt = 1; cycle();
    for (int i = 0; i < 5; i++) begin
      ihit = 1'($urandom); wb_halt = 1'($urandom); ex_redirect = 1'($urandom);
      mem_dREN = 1'($urandom); dhit = 1'($urandom);
      cycle();
    end
    checkEq("halt_sticky", int'(ctlA[1]), 1);
    doReset();
    checkEq("halt_cleared", int'(ctlA[1]), 0);

    // Watchdog and counter saturation on the small instance.
    mem_dREN = 1;
    repeat (6) cycle();
    checkEq("wd_timeoutB", int'(ctlB[0]), 1);
    checkEq("wd_stallB_sat", int'(stallB), 3);
    dhit = 1; cycle();
    idle(); cycle();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom_range(0, 199) == 0);
      wb_halt     = ($urandom_range(0, 59) == 0);
      ihit        = ($urandom_range(0, 9) < 8);
      mem_dREN    = ($urandom_range(0, 9) < 2);
      mem_dWEN    = ($urandom_range(0, 9) < 1);
      dhit        = ($urandom_range(0, 9) < (n % 400 < 200 ? 6 : 1));
      ex_redirect = ($urandom_range(0, 99) < 15);
      ex_dREN     = ($urandom_range(0, 9) < 4);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives the en/flush/freeze controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable, based on four conditions: cache hits, EX-stage redirects, load-use hazards and halt retirement. It tracks outstanding data-memory waits and the halted state, and exposes saturating stall and flush counters plus a memory-wait watchdog.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)
TIMEOUT, 1024, consecutive DWAIT cycles before mem_timeout sets

Ports:
CLK  in  1  core clock; only clock in the block
RST  in  1  synchronous, active-high reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access in MEM stage completes this cycle
mem_dREN  in  1  EX/MEM latch holds a load
mem_dWEN  in  1  EX/MEM latch holds a store
ex_redirect  in  1  branch taken or jump resolved in EX
ex_dREN  in  1  ID/EX latch holds a load
ex_rd  in  5  destination register of ID/EX instruction
id_rs1  in  5  source 1 of IF/ID instruction
id_rs2  in  5  source 2 of IF/ID instruction
wb_halt  in  1  halt instruction in MEM/WB latch
pc_en  out  1  PC register update enable
ifid_en, ifid_flush  out  1 each  IF/ID controls
idex_en, idex_flush, idex_freeze  out  1 each  ID/EX controls (freeze = bubble insert)
exmem_en, exmem_flush  out  1 each  EX/MEM controls
memwb_en, memwb_flush  out  1 each  MEM/WB controls
halt  out  1  sticky: core halted
mem_timeout  out  1  sticky: DWAIT exceeded TIMEOUT
stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN/DWAIT
flush_cnt  out  CNT_W  redirect count

Behaviour:
- Interface: one clock (CLK). Reset is synchronous and active-high (RST). All state updates occur on posedge CLK.
- While RST=1, all outputs combinationally read 0. At the next edge: state=RUN, halt=0, mem_timeout=0, counters=0, dwait_cnt=0. A reset mid-DWAIT or while HALTED always returns the block to RUN.
- States: RUN, DWAIT, HALTED. Latch controls are combinational from state and inputs (zero latency). State, halt, counters and the watchdog update on the edge.
- memop = mem_dREN | mem_dWEN. dstall = memop & ~dhit. lu = ex_dREN & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority in RUN/DWAIT is evaluated top-down; the first match wins. Any control not named below is 0.
  1. wb_halt: all en=0; next state=HALTED.
  2. dstall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush=1. Redirects and load-use are deferred and re-evaluated each cycle. Next state=DWAIT.
  3. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1. Redirect overrides lu and an ihit miss. flush_cnt += 1.
  4. lu: pc_en=0, ifid_en=0, idex_freeze=1, exmem_en=1, memwb_en=1. Exactly one bubble is inserted per hazard occurrence.
  5. ~ihit: pc_en=0, ifid_flush=1, idex_en, exmem_en, memwb_en = 1.
  6. Otherwise: pc_en and all *_en = 1.
- DWAIT → RUN on the first cycle dhit=1. That cycle is evaluated with rules 3–6.
- dwait_cnt increments each DWAIT cycle and clears on leaving DWAIT. When dwait_cnt reaches TIMEOUT-1 while still in DWAIT, mem_timeout sets. mem_timeout is cleared only by RST and does not alter pipeline control.
- HALTED: all en/flush/freeze=0 and halt=1 until RST. Counters freeze.
- stall_cnt increments on any RUN/DWAIT cycle with pc_en=0, excluding the wb_halt cycle. Both counters saturate at all-ones; there is no wrap.
- Simultaneous dstall & ex_redirect: the redirect is held; the EX latch keeps ex_redirect asserted because idex_en=0. It is applied on the dhit cycle.

Decomposition:
- cpu_types_pkg gains pctrl_state_t (enum RUN, DWAIT, HALTED). Reuse regbits_t for the 5-bit register indices.
- One sub-module: pctrl_sat_cnt (parameter W; ports inc, clr; saturating), instantiated twice for stall_cnt and flush_cnt. Hazard compare stays inline.

Test Plan:
- Reset: hold RST=1 for 2 cycles with ihit=1 → all outputs 0. Release → pc_en=1 and all *_en=1 in the first cycle, counters 0.
- Load-use: ex_dREN=1, ex_rd=5, id_rs2=5, ihit=1 → one cycle with pc_en=0, ifid_en=0, idex_freeze=1, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- D-miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 frozen cycles with memwb_flush=1, state DWAIT, stall_cnt=3. Return to RUN with full enables on the dhit cycle.
- Redirect vs stall: ex_redirect=1 and dstall for 2 cycles → flushes suppressed. On the dhit cycle, ifid_flush=idex_flush=1 and flush_cnt=1. Redirect with ihit=0 → pc_en=1.
- Halt: wb_halt=1 → all en=0. From the next cycle halt=1 and stays 1 with toggling inputs; RST clears it.
- Watchdog/saturation: TIMEOUT=4, CNT_W=2, dstall held for 6 cycles → mem_timeout=1 after the 4th DWAIT cycle and stall_cnt sticks at 3.
